// File: rtl/fwd_scoreboard_pkg.sv
// Shared codes and record type for the forwarding scoreboard.
// The readiness rule lives here so every operand mux applies the same one.
package fwd_scoreboard_pkg;

    localparam logic [4:0] BR_NONE = 5'd0;
    localparam logic [4:0] BR_BEQ  = 5'd1;
    localparam logic [4:0] BR_BNE  = 5'd2;
    localparam logic [4:0] BR_BGEZ = 5'd3;
    localparam logic [4:0] BR_BGTZ = 5'd4;
    localparam logic [4:0] BR_BLEZ = 5'd5;
    localparam logic [4:0] BR_BLTZ = 5'd6;

    localparam logic [2:0] NPC_PC4 = 3'd0;
    localparam logic [2:0] NPC_B   = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

    localparam logic [2:0] WB_ALU = 3'd0;
    localparam logic [2:0] WB_RS  = 3'd1;
    localparam logic [2:0] WB_RAM = 3'd2;
    localparam logic [2:0] WB_HI  = 3'd3;
    localparam logic [2:0] WB_LO  = 3'd4;
    localparam logic [2:0] WB_PC8 = 3'd5;

    typedef struct packed {
        logic       valid;
        logic [4:0] wreg;
        logic [2:0] wsel;
    } fwd_rec_t;

    localparam fwd_rec_t REC_NONE = '{valid: 1'b0, wreg: 5'd0, wsel: 3'd0};

    // A producer's result is usable once its class has produced final data.
    function automatic logic rec_ready(input logic [2:0] wsel,
                                       input logic       load_ok,
                                       input logic       md_busy);
        logic rdy;
        case (wsel)
            WB_RAM:       rdy = load_ok;
            WB_HI, WB_LO: rdy = ~md_busy;
            default:      rdy = 1'b1;
        endcase
        return rdy;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_operand_mux.sv
// One-operand forwarding: youngest matching producer wins, flags a hazard
// when that producer's data is not final yet.
module fwd_operand_mux
    import fwd_scoreboard_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 3,
    parameter int LOAD_STG = 1
) (
    input  fwd_rec_t [DEPTH-1:0]      recs,
    input  logic [DEPTH*XLEN-1:0]     stg_data,
    input  logic [XLEN-1:0]           rf_rdata,
    input  logic [4:0]                src,
    input  logic                      md_busy,
    output logic [XLEN-1:0]           rdata,
    output logic                      hazard
);

    logic hit_s;

    // Walk oldest to youngest so the lowest stage index overrides the rest.
    always_comb begin
        rdata  = (src == 5'd0) ? {XLEN{1'b0}} : rf_rdata;
        hazard = 1'b0;
        hit_s  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            hit_s  = recs[k].valid && (recs[k].wreg == src) && (src != 5'd0);
            rdata  = hit_s ? stg_data[k*XLEN +: XLEN] : rdata;
            hazard = hit_s ? ~rec_ready(recs[k].wsel, (k >= LOAD_STG), md_busy) : hazard;
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// ID-stage forwarding scoreboard: tracks in-flight writers, forwards operands,
// raises load-use / mul-div stalls and resolves branches and jumps.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 3,
    parameter int LOAD_STG = 1,
    parameter int MD_LAT   = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ext_stall,
    input  logic                  id_valid,
    input  logic                  id_wen,
    input  logic                  id_is_md,
    input  logic                  id_reads_hilo,
    input  logic [4:0]            id_rs,
    input  logic [4:0]            id_rt,
    input  logic [4:0]            id_wreg,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [2:0]            id_wsel,
    input  logic [4:0]            id_br_op,
    input  logic [2:0]            id_npc_op,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [XLEN-1:0]       rf_rdata1,
    input  logic [XLEN-1:0]       rf_rdata2,
    input  logic [DEPTH*XLEN-1:0] stg_data,
    output logic [XLEN-1:0]       out_rdata1,
    output logic [XLEN-1:0]       out_rdata2,
    output logic                  stall,
    output logic                  jmp,
    output logic [XLEN-1:0]       dest,
    output logic                  md_busy
);

    localparam int MD_CNT_W = $clog2(MD_LAT + 1);

    fwd_rec_t [DEPTH-1:0] rec_q, rec_d;
    logic [MD_CNT_W-1:0]  md_cnt_q, md_cnt_d;
    logic                 md_busy_s, stall_s, haz1_s, haz2_s, taken_s, pass_s;
    logic [XLEN-1:0]      op1_raw_s, op2_raw_s, op1_s, op2_s, pc4_s, dest_s;

    assign md_busy_s = (md_cnt_q != {MD_CNT_W{1'b0}});

    fwd_operand_mux #(.XLEN(XLEN), .DEPTH(DEPTH), .LOAD_STG(LOAD_STG)) u_mux_rs (
        .recs(rec_q), .stg_data(stg_data), .rf_rdata(rf_rdata1), .src(id_rs),
        .md_busy(md_busy_s), .rdata(op1_raw_s), .hazard(haz1_s)
    );

    fwd_operand_mux #(.XLEN(XLEN), .DEPTH(DEPTH), .LOAD_STG(LOAD_STG)) u_mux_rt (
        .recs(rec_q), .stg_data(stg_data), .rf_rdata(rf_rdata2), .src(id_rt),
        .md_busy(md_busy_s), .rdata(op2_raw_s), .hazard(haz2_s)
    );

    assign stall_s = id_valid & ((id_use_rs & haz1_s) | (id_use_rt & haz2_s) |
                                 ((id_reads_hilo | id_is_md) & md_busy_s));
    // Operands are zeroed while stalled or in reset; branch logic sees the gated values.
    assign pass_s  = resetn & ~stall_s;
    assign op1_s   = pass_s ? op1_raw_s : {XLEN{1'b0}};
    assign op2_s   = pass_s ? op2_raw_s : {XLEN{1'b0}};
    assign pc4_s   = id_pc + XLEN'(4);

    // Next state: shift records toward WB, insert ID writer or a bubble, run the md countdown.
    always_comb begin
        rec_d    = rec_q;
        md_cnt_d = md_cnt_q;
        if (!ext_stall) begin
            for (int k = 1; k < DEPTH; k++) begin
                rec_d[k] = rec_q[k-1];
            end
            if (id_valid && id_wen && (id_wreg != 5'd0) && !stall_s) begin
                rec_d[0] = '{valid: 1'b1, wreg: id_wreg, wsel: id_wsel};
            end else begin
                rec_d[0] = REC_NONE;
            end
            if (id_valid && id_is_md && !stall_s) begin
                md_cnt_d = MD_CNT_W'(MD_LAT);
            end else if (md_busy_s) begin
                md_cnt_d = md_cnt_q - MD_CNT_W'(1);
            end else begin
                md_cnt_d = md_cnt_q;
            end
        end else begin
            rec_d    = rec_q;
            md_cnt_d = md_cnt_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) begin
                rec_q[k] <= REC_NONE;
            end
            md_cnt_q <= {MD_CNT_W{1'b0}};
        end else begin
            rec_q    <= rec_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Branch condition and redirect target.
    always_comb begin
        taken_s = 1'b0;
        dest_s  = {XLEN{1'b0}};
        case (id_npc_op)
            NPC_B: begin
                dest_s = pc4_s + id_imm;
                case (id_br_op)
                    BR_BEQ:  taken_s = (op1_s == op2_s);
                    BR_BNE:  taken_s = (op1_s != op2_s);
                    BR_BGEZ: taken_s = ~op1_s[XLEN-1];
                    BR_BGTZ: taken_s = ~op1_s[XLEN-1] & (op1_s != {XLEN{1'b0}});
                    BR_BLEZ: taken_s = op1_s[XLEN-1] | (op1_s == {XLEN{1'b0}});
                    BR_BLTZ: taken_s = op1_s[XLEN-1];
                    default: taken_s = 1'b0;
                endcase
            end
            NPC_J: begin
                taken_s = 1'b1;
                dest_s  = {pc4_s[XLEN-1:XLEN-4], id_imm[XLEN-5:0]};
            end
            NPC_JR: begin
                taken_s = 1'b1;
                dest_s  = op1_s;
            end
            default: begin
                taken_s = 1'b0;
                dest_s  = {XLEN{1'b0}};
            end
        endcase
    end

    assign out_rdata1 = op1_s;
    assign out_rdata2 = op2_s;
    assign stall      = resetn & stall_s;
    assign jmp        = pass_s & id_valid & taken_s;
    assign dest       = resetn ? dest_s : {XLEN{1'b0}};
    assign md_busy    = resetn & md_busy_s;

endmodule
